// File: rtl/divide_fix_pkg.sv
// Shared widths, FSM state and result record for the 40/8 fixed-point divide issuer.
package divide_fix_pkg;

    localparam int DIV_A_W = 40;
    localparam int DIV_B_W = 8;
    localparam int DIV_R_W = 64;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [DIV_R_W-1:0] data;
        logic               dz;
    } result_t;

endpackage

// File: rtl/divide_fix_result_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop together are accepted even when full.
module divide_fix_result_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/divide_fix_issuer_40_8.sv
// Issues 40/8 operand pairs to a fixed-latency divider and buffers results under credit control.
// Optional per-operation divide-by-zero flag path: DIVIDE_FIX_ISSUER_DZ_FLAG_EN.
module divide_fix_issuer_40_8
    import divide_fix_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DIV_LATENCY = 20
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_axis_req_tvalid,
    output logic               s_axis_req_tready,
    input  logic [DIV_A_W-1:0] s_axis_req_a,
    input  logic [DIV_B_W-1:0] s_axis_req_b,
    output logic               m_div_a_tvalid,
    output logic               m_div_b_tvalid,
    output logic [DIV_A_W-1:0] m_div_a_tdata,
    output logic [DIV_B_W-1:0] m_div_b_tdata,
    input  logic               s_div_result_tvalid,
    input  logic [DIV_R_W-1:0] s_div_result_tdata,
    output logic               m_axis_result_tvalid,
    input  logic               m_axis_result_tready,
    output logic [DIV_R_W-1:0] m_axis_result_tdata,
    output logic               m_axis_result_tuser,
    output logic               err_unexpected
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int FCW = $clog2(DIV_LATENCY + 1);

    state_e             state_q, state_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               div_valid_q, div_valid_d;
    logic [DIV_A_W-1:0] div_a_q, div_a_d;
    logic [DIV_B_W-1:0] div_b_q, div_b_d;
    logic               err_q, err_d;

    logic [CW:0]        credit_used;
    logic               accept;
    logic               res_in_run;
    logic               res_ok;
    logic               res_unexp;
    result_t            res_push_data;
    result_t            res_head;
    logic [CW-1:0]      res_count;
    logic               res_empty;
    logic               res_full_unused;

    // Credit covers both buffered results and results still inside the divider.
    assign credit_used       = {1'b0, inflight_q} + {1'b0, res_count};
    assign s_axis_req_tready = (state_q == RUN) && (credit_used < (CW+1)'(DEPTH));
    assign accept            = s_axis_req_tvalid && s_axis_req_tready;
    assign res_in_run        = s_div_result_tvalid && (state_q == RUN);
    assign res_ok            = res_in_run && (inflight_q != '0);
    assign res_unexp         = res_in_run && (inflight_q == '0);

`ifdef DIVIDE_FIX_ISSUER_DZ_FLAG_EN
    logic          dz_head;
    logic [CW-1:0] flag_count_unused;
    logic          flag_empty_unused;
    logic          flag_full_unused;

    // Flags ride alongside the in-flight operations and join their result on return.
    divide_fix_result_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_flag_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (accept),
        .push_data (s_axis_req_b == '0),
        .pop       (res_ok),
        .pop_data  (dz_head),
        .count     (flag_count_unused),
        .empty     (flag_empty_unused),
        .full      (flag_full_unused)
    );

    always_comb begin
        res_push_data.dz   = dz_head;
        res_push_data.data = dz_head ? {DIV_R_W{1'b1}} : s_div_result_tdata;
    end
`else
    always_comb begin
        res_push_data.dz   = 1'b0;
        res_push_data.data = s_div_result_tdata;
    end
`endif

    divide_fix_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (res_ok),
        .push_data (res_push_data),
        .pop       (m_axis_result_tready),
        .pop_data  (res_head),
        .count     (res_count),
        .empty     (res_empty),
        .full      (res_full_unused)
    );

    // Head data is masked while empty so the uninitialised storage never reaches the port.
    assign m_axis_result_tvalid = !res_empty;
    assign m_axis_result_tdata  = res_empty ? '0 : res_head.data;
    assign m_axis_result_tuser  = !res_empty && res_head.dz;

    assign m_div_a_tvalid = div_valid_q;
    assign m_div_b_tvalid = div_valid_q;
    assign m_div_a_tdata  = div_a_q;
    assign m_div_b_tdata  = div_b_q;
    assign err_unexpected = err_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        inflight_d  = inflight_q;
        div_valid_d = accept;
        div_a_d     = accept ? s_axis_req_a : div_a_q;
        div_b_d     = accept ? s_axis_req_b : div_b_q;
        err_d       = err_q | res_unexp;

        case (state_q)
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FCW'(1);
                if (flush_cnt_q == FCW'(DIV_LATENCY - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = FLUSH;
        endcase

        case ({accept, res_ok})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; all next-state math lives above.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            inflight_q  <= '0;
            div_valid_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            inflight_q  <= inflight_d;
            div_valid_q <= div_valid_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_divide_fix_issuer_40_8.sv
// Bench for divide_fix_issuer_40_8: divider model, scoreboard monitor and per-scenario tasks.
module tb_divide_fix_issuer_40_8;
    import divide_fix_pkg::*;

    localparam int DEPTH       = 16;
    localparam int DIV_LATENCY = 20;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               s_axis_req_tvalid = 1'b0;
    logic               s_axis_req_tready;
    logic [DIV_A_W-1:0] s_axis_req_a = '0;
    logic [DIV_B_W-1:0] s_axis_req_b = '0;
    logic               m_div_a_tvalid, m_div_b_tvalid;
    logic [DIV_A_W-1:0] m_div_a_tdata;
    logic [DIV_B_W-1:0] m_div_b_tdata;
    logic               s_div_result_tvalid;
    logic [DIV_R_W-1:0] s_div_result_tdata;
    logic               m_axis_result_tvalid;
    logic               m_axis_result_tready = 1'b0;
    logic [DIV_R_W-1:0] m_axis_result_tdata;
    logic               m_axis_result_tuser;
    logic               err_unexpected;

    logic               inj_valid = 1'b0;
    logic [DIV_R_W-1:0] inj_data = '0;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;
    bit      mon_en = 1'b0;
    bit      credit_en = 1'b0;

    typedef struct {
        logic [DIV_R_W-1:0] data;
        logic               dz;
    } exp_t;
    exp_t sb[$];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    divide_fix_issuer_40_8 #(
        .DEPTH       (DEPTH),
        .DIV_LATENCY (DIV_LATENCY)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_req_tvalid    (s_axis_req_tvalid),
        .s_axis_req_tready    (s_axis_req_tready),
        .s_axis_req_a         (s_axis_req_a),
        .s_axis_req_b         (s_axis_req_b),
        .m_div_a_tvalid       (m_div_a_tvalid),
        .m_div_b_tvalid       (m_div_b_tvalid),
        .m_div_a_tdata        (m_div_a_tdata),
        .m_div_b_tdata        (m_div_b_tdata),
        .s_div_result_tvalid  (s_div_result_tvalid),
        .s_div_result_tdata   (s_div_result_tdata),
        .m_axis_result_tvalid (m_axis_result_tvalid),
        .m_axis_result_tready (m_axis_result_tready),
        .m_axis_result_tdata  (m_axis_result_tdata),
        .m_axis_result_tuser  (m_axis_result_tuser),
        .err_unexpected       (err_unexpected)
    );

    // Q.12 quotient; a recognisable pattern stands in for divide-by-zero.
    function automatic logic [DIV_R_W-1:0] div_model(input logic [DIV_A_W-1:0] a,
                                                      input logic [DIV_B_W-1:0] b);
        if (b == '0) return {24'hDEAD00, a};
        return ({24'd0, a} << 12) / {56'd0, b};
    endfunction

    function automatic exp_t expect_of(input logic [DIV_A_W-1:0] a, input logic [DIV_B_W-1:0] b);
        exp_t e;
`ifdef DIVIDE_FIX_ISSUER_DZ_FLAG_EN
        e.dz   = (b == '0);
        e.data = e.dz ? {DIV_R_W{1'b1}} : div_model(a, b);
`else
        e.dz   = 1'b0;
        e.data = div_model(a, b);
`endif
        return e;
    endfunction

    // Fixed-latency divider: a request seen in cycle N returns in cycle N+DIV_LATENCY.
    logic               pv [0:DIV_LATENCY];
    logic [DIV_R_W-1:0] pd [0:DIV_LATENCY];
    initial begin
        for (int i = 0; i <= DIV_LATENCY; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
    end
    always @(negedge aclk) begin
        for (int i = DIV_LATENCY; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = (m_div_a_tvalid === 1'b1);
        pd[0] = div_model(m_div_a_tdata, m_div_b_tdata);
    end
    assign s_div_result_tvalid = pv[DIV_LATENCY] | inj_valid;
    assign s_div_result_tdata  = inj_valid ? inj_data : pd[DIV_LATENCY];

    // Scoreboard monitor: credit check, then pop/compare, then push on accept.
    always @(negedge aclk) begin
        exp_t e;
        if (mon_en && !areset) begin
            if (credit_en) begin
                checks++;
                if (s_axis_req_tready !== (sb.size() < DEPTH)) begin
                    errors++;
                    $display("FAIL credit_ready got %0b want %0b (outstanding %0d)",
                             s_axis_req_tready, (sb.size() < DEPTH), sb.size());
                end
            end
            if (m_axis_result_tvalid === 1'b1 && m_axis_result_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra got %h with empty scoreboard", m_axis_result_tdata);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_result_tdata !== e.data || m_axis_result_tuser !== e.dz) begin
                        errors++;
                        $display("FAIL result_order got %h/%0b want %h/%0b",
                                 m_axis_result_tdata, m_axis_result_tuser, e.data, e.dz);
                    end
                end
            end
            if (s_axis_req_tvalid && s_axis_req_tready === 1'b1)
                sb.push_back(expect_of(s_axis_req_a, s_axis_req_b));
        end
    end

    task automatic send(input logic [DIV_A_W-1:0] a, input logic [DIV_B_W-1:0] b,
                        output longint acc_cyc);
        int n;
        @(posedge aclk); #1;
        s_axis_req_tvalid = 1'b1;
        s_axis_req_a      = a;
        s_axis_req_b      = b;
        n = 0;
        @(negedge aclk);
        while (s_axis_req_tready !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (s_axis_req_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got tready %0b want 1", s_axis_req_tready);
        end
        acc_cyc = cyc;
    endtask

    task automatic idle();
        @(posedge aclk); #1;
        s_axis_req_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        @(posedge aclk); #1;
        m_axis_result_tready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || m_axis_result_tvalid !== 1'b0) && n < 400) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        mon_en    = 1'b0;
        credit_en = 1'b0;
        @(posedge aclk); #1;
        areset               = 1'b1;
        s_axis_req_tvalid    = 1'b0;
        inj_valid            = 1'b0;
        m_axis_result_tready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({s_axis_req_tready, m_div_a_tvalid, m_div_b_tvalid, m_axis_result_tvalid,
             m_axis_result_tuser, err_unexpected} !== 6'b0 || m_axis_result_tdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy%0b dv%0b%0b rv%0b u%0b err%0b want all 0",
                     s_axis_req_tready, m_div_a_tvalid, m_div_b_tvalid, m_axis_result_tvalid,
                     m_axis_result_tuser, err_unexpected);
        end
        sb.delete();
        @(posedge aclk); #1;
        areset = 1'b0;
        for (int i = 0; i <= DIV_LATENCY; i++) begin
            inj_valid = (i < DIV_LATENCY) && (i % 3 == 0);
            inj_data  = 64'h0BAD_0000_0000_0000 | 64'(i);
            @(negedge aclk);
            checks++;
            if (s_axis_req_tready !== (i == DIV_LATENCY)) begin
                errors++;
                $display("FAIL flush_tready cycle %0d got %0b want %0b",
                         i, s_axis_req_tready, (i == DIV_LATENCY));
            end
            @(posedge aclk); #1;
        end
        inj_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if (err_unexpected !== 1'b0 || m_axis_result_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got err %0b valid %0b want 0 0",
                     err_unexpected, m_axis_result_tvalid);
        end
        mon_en    = 1'b1;
        credit_en = 1'b1;
    endtask

    task automatic test_single();
        longint acc;
        int     n;
        m_axis_result_tready = 1'b1;
        send(40'd1000, 8'd10, acc);
        idle();
        @(negedge aclk);
        checks++;
        if (m_div_a_tvalid !== 1'b1 || m_div_b_tvalid !== 1'b1 ||
            m_div_a_tdata !== 40'd1000 || m_div_b_tdata !== 8'd10) begin
            errors++;
            $display("FAIL issue got v%0b%0b a %0d b %0d want v11 a 1000 b 10",
                     m_div_a_tvalid, m_div_b_tvalid, m_div_a_tdata, m_div_b_tdata);
        end
        @(negedge aclk);
        checks++;
        if (m_div_a_tvalid !== 1'b0 || m_div_b_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL issue_pulse got v%0b%0b want v00", m_div_a_tvalid, m_div_b_tvalid);
        end
        n = 0;
        while (m_axis_result_tvalid !== 1'b1 && n < 60) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (cyc - acc != DIV_LATENCY + 2 || m_axis_result_tdata !== 64'd409600 ||
            m_axis_result_tuser !== 1'b0) begin
            errors++;
            $display("FAIL single_op got latency %0d data %0d user %0b want %0d 409600 0",
                     cyc - acc, m_axis_result_tdata, m_axis_result_tuser, DIV_LATENCY + 2);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        longint acc;
        @(posedge aclk); #1;
        m_axis_result_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(40'(i * 1000 + 7), 8'(i + 1), acc);
        idle();
        @(negedge aclk);
        checks++;
        if (s_axis_req_tready !== 1'b0) begin
            errors++;
            $display("FAIL full_tready got %0b want 0", s_axis_req_tready);
        end
        repeat (DIV_LATENCY + 4) @(negedge aclk);
        checks++;
        if (m_axis_result_tvalid !== 1'b1 || s_axis_req_tready !== 1'b0 || sb.size() != DEPTH) begin
            errors++;
            $display("FAIL buffered got valid %0b tready %0b outstanding %0d want 1 0 %0d",
                     m_axis_result_tvalid, s_axis_req_tready, sb.size(), DEPTH);
        end
        @(posedge aclk); #1;
        m_axis_result_tready = 1'b1;
        @(posedge aclk); #1;
        m_axis_result_tready = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_axis_req_tready !== 1'b1) begin
            errors++;
            $display("FAIL pop_restores_tready got %0b want 1", s_axis_req_tready);
        end
        drain();
    endtask

    task automatic test_random();
        longint acc;
        bit     done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 9) == 0) idle();
                    send(40'({$urandom(), $urandom()}), 8'($urandom_range(0, 255)), acc);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk); #1;
                    m_axis_result_tready = ($urandom_range(0, 99) < 30);
                end
            end
        join
        drain();
        checks++;
        if (err_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL random_err got %0b want 0", err_unexpected);
        end
    endtask

    task automatic test_div_zero();
        longint             acc;
        int                 n;
        logic [DIV_R_W-1:0] want_data;
        logic               want_user;
`ifdef DIVIDE_FIX_ISSUER_DZ_FLAG_EN
        want_data = {DIV_R_W{1'b1}};
        want_user = 1'b1;
`else
        want_data = div_model(40'd5, 8'd0);
        want_user = 1'b0;
`endif
        m_axis_result_tready = 1'b1;
        send(40'd5, 8'd0, acc);
        idle();
        n = 0;
        while (m_axis_result_tvalid !== 1'b1 && n < 60) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (m_axis_result_tdata !== want_data || m_axis_result_tuser !== want_user) begin
            errors++;
            $display("FAIL div_zero got %h/%0b want %h/%0b",
                     m_axis_result_tdata, m_axis_result_tuser, want_data, want_user);
        end
        drain();
    endtask

    task automatic test_unexpected();
        longint acc;
        @(posedge aclk); #1;
        inj_valid = 1'b1;
        inj_data  = 64'h1234;
        @(posedge aclk); #1;
        inj_valid = 1'b0;
        @(negedge aclk);
        checks++;
        if (err_unexpected !== 1'b1 || m_axis_result_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL unexpected got err %0b valid %0b want 1 0",
                     err_unexpected, m_axis_result_tvalid);
        end
        send(40'd77, 8'd7, acc);
        idle();
        drain();
        checks++;
        if (err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %0b want 1", err_unexpected);
        end
        // Leave operations in flight so the following reset has to discard them.
        for (int i = 0; i < 3; i++) send(40'(i + 300), 8'd3, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_div_zero();
        test_unexpected();
        test_reset();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
